// File: rtl/ncca_seq_ctrl.sv
// ncca_seq_ctrl: sequential 8x8 unsigned multiplier controller built around one shared 4x4
// sub-multiplier. The four nibble partial products are issued one per cycle in the order
// LL, LH, HL, HH and accumulated into a 16-bit result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, exact_mode)
//   sub_a/sub_b         nibble operands to the shared sub-multiplier
//   sub_exact           1 = exact sub-multiplier, 0 = approximate
//   sub_prod            combinational sub-multiplier result for the current nibble pair
//   out_valid/out_ready result handshake; prod reads 0 when out_valid is low
//   busy                high whenever the controller is not idle
//   op_count            results delivered, modulo 256
module ncca_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        exact_mode,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic        sub_exact,
  input  logic [7:0]  sub_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy,
  output logic [7:0]  op_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLl   = 3'd1;
  localparam logic [2:0] StLh   = 3'd2;
  localparam logic [2:0] StHl   = 3'd3;
  localparam logic [2:0] StHh   = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        exact_q, exact_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;

  // In DONE a new operand pair is only taken together with the result handshake.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign prod      = out_valid ? acc_q : 16'h0000;
  assign busy      = (state_q != StIdle);
  assign op_count  = cnt_q;

  // Nibble selection for the shared sub-multiplier; LL is always exact.
  always_comb begin
    sub_a     = 4'h0;
    sub_b     = 4'h0;
    sub_exact = 1'b0;
    case (state_q)
      StLl: begin
        sub_a     = a_q[3:0];
        sub_b     = b_q[3:0];
        sub_exact = 1'b1;
      end
      StLh: begin
        sub_a     = a_q[3:0];
        sub_b     = b_q[7:4];
        sub_exact = exact_q;
      end
      StHl: begin
        sub_a     = a_q[7:4];
        sub_b     = b_q[3:0];
        sub_exact = exact_q;
      end
      StHh: begin
        sub_a     = a_q[7:4];
        sub_b     = b_q[7:4];
        sub_exact = exact_q;
      end
      default: begin
        sub_a     = 4'h0;
        sub_b     = 4'h0;
        sub_exact = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    exact_d = exact_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StLl;
      end
      StLl: begin
        acc_d   = acc_q + {8'h00, sub_prod};
        state_d = StLh;
      end
      StLh: begin
        acc_d   = acc_q + {4'h0, sub_prod, 4'h0};
        state_d = StHl;
      end
      StHl: begin
        acc_d   = acc_q + {4'h0, sub_prod, 4'h0};
        state_d = StHh;
      end
      StHh: begin
        // Carry out of bit 15 is intentionally dropped.
        acc_d   = acc_q + {sub_prod, 8'h00};
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = accept ? StLl : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      a_d     = a;
      b_d     = b;
      exact_d = exact_mode;
      acc_d   = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      exact_q <= 1'b0;
      acc_q   <= 16'h0000;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exact_q <= exact_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
